ghost_mode_ctrl: RTL and testbench
==================================

# ghost_mode_ctrl

Frame-rate mode controller for the green ghost. It owns the frightened ("blue") timer and the Pac-Man/ghost collision check, and it produces the `blue`, `overg` and `over` controls consumed by the ghost motion stage. It reads back that stage's `GhostX`/`GhostY` every frame, together with the player position and a power-pellet pulse from the maze/pellet logic.

## Interface
Parameters:
- `BLUE_FRAMES`, default 300: frightened duration in frames (10 s at 30 Hz).
- `FLASH_FRAMES`, default 90: final portion of the frightened period that is flagged for flashing.
- `RESPAWN_FRAMES`, default 60: frames the ghost stays harmless after being eaten.
- `HIT_DIST`, default 8: collision threshold in pixels, per axis, strict less-than.

Ports:
- `frame_clk` in, 1: frame clock (~30 Hz); the only clock.
- `Reset_n` in, 1: asynchronous, active-low reset.
- `BallX`, `BallY` in, 11 each: Pac-Man centre, unsigned pixels.
- `GhostX`, `GhostY` in, 11 each: ghost centre from the ghost motion stage.
- `power_pellet` in, 1: high for one frame when a power pellet is eaten.
- `blue` out, 1: frightened mode active.
- `blue_flash` out, 1: frightened mode with `timer <= FLASH_FRAMES`.
- `overg` out, 1: ghost-eaten pulse, exactly one frame; used downstream as a ghost position reset.
- `over` out, 1: player caught; held until reset.
- `eaten_count` out, 8: number of ghosts eaten, saturating at 255.

## Operation
- **Collision (`hit`)**: combinational from the current inputs. `hit = (|BallX−GhostX| < HIT_DIST) && (|BallY−GhostY| < HIT_DIST)`.
  - Absolute difference is formed by comparing the operands, then subtracting the smaller from the larger. No signed wrap.
- **Timer**: 9-bit frame counter, `timer`.
- **State machine**, with states CHASE, FRIGHT, EATEN, CAUGHT. Evaluated once per frame, in the priority order listed within each state.
  - **CHASE**:
    - `hit` → CAUGHT.
    - Else `power_pellet` → FRIGHT, `timer <= BLUE_FRAMES`.
  - **FRIGHT**:
    - `hit` → EATEN, `timer <= RESPAWN_FRAMES`, `overg` pulse, `eaten_count` +1 (saturating).
    - Else `power_pellet` → stay in FRIGHT, `timer <= BLUE_FRAMES` (reload).
    - Else `timer == 1` → CHASE, `timer <= 0`.
    - Else `timer <= timer − 1`.
  - **EATEN**:
    - `hit` and `power_pellet` are ignored.
    - `timer` decrements each frame; `timer == 1` → CHASE.
  - **CAUGHT**: terminal state. Only `Reset_n` leaves it.
- **Output decode** (from the registered state):
  - `blue` = (state == FRIGHT).
  - `blue_flash` = `blue && timer <= FLASH_FRAMES`.
  - `over` = (state == CAUGHT).
- **Registered, glitch-free outputs**: `overg` and `over` are flops, because the downstream stage uses them as asynchronous position resets.
- **Parameter check**: `BLUE_FRAMES`, `RESPAWN_FRAMES` ≥ 1 and ≤ 511. Elaboration error otherwise.

## Timing
- **Reset** (`Reset_n` low, asynchronous): state CHASE, `timer` 0, `blue` 0, `blue_flash` 0, `overg` 0, `over` 0, `eaten_count` 0. Any in-progress frightened or respawn period is abandoned.
- **Latency**: one frame from an input condition to the output change. The qualifying edge is the first `frame_clk` rising edge at which the condition is sampled.
- **`overg`**:
  - High for exactly the one frame following the eating edge.
  - Low on the next edge even if `hit` persists, because the state is then EATEN.
- **Frightened duration**: after a pellet at edge N, `blue` is high from edge N through edge N+BLUE_FRAMES−1, i.e. for BLUE_FRAMES frames. It is low from edge N+BLUE_FRAMES.
- **Simultaneous events**:
  - `hit` and `power_pellet` in CHASE: caught (player loses).
  - Both in FRIGHT: ghost eaten, pellet discarded.
  - `power_pellet` in the final FRIGHT frame (`timer == 1`): reloads the timer and stays in FRIGHT.
- **Ghost position while EATEN**: `GhostX`/`GhostY` are at home after `overg`, but collisions are ignored regardless for RESPAWN_FRAMES.
- **Held inputs**: a `power_pellet` held for several frames reloads the timer on each of those frames. This is not an error.

## Test plan
- **Reset and idle catch**: deassert reset with Ball (100,100), Ghost (300,300) for 10 frames → all outputs 0. Then move Ghost to (105,96) → `over` = 1 one frame later, and it stays 1 with no further outputs changing.
- **Frightened timeout**: pulse `power_pellet` → `blue` = 1 for exactly 300 frames. `blue_flash` rises when `timer` = 90 and `blue` falls at frame 300.
- **Ghost eaten**: in FRIGHT, set Ghost = Ball + (7,0) → `overg` high exactly 1 frame, `eaten_count` = 1, `blue` = 0. Hold `hit` → no CAUGHT for 60 frames, then CHASE, and the held `hit` causes `over` on the following frame.
- **Boundary distance**: Ghost = Ball + (8,0) in FRIGHT → no hit. With BallX = 0 and GhostX = 2047, no wrap hit.
- **Pellet reload**: pellet at frame 0, again at frame 250 → `blue` stays high through frame 549 and falls at frame 550.
- **Mid-operation reset and saturation**: assert `Reset_n` = 0 mid-FRIGHT (timer 150) → outputs cleared immediately, without waiting for a clock edge. Force 300 eat cycles → `eaten_count` holds at 255.

Source files
------------

// File: rtl/ghost_mode_ctrl.sv
// Frame-rate mode controller for the green ghost: frightened timer, collision
// check, and the registered blue/overg/over controls for the ghost motion stage.
module ghost_mode_ctrl #(
  parameter int BLUE_FRAMES    = 300,
  parameter int FLASH_FRAMES   = 90,
  parameter int RESPAWN_FRAMES = 60,
  parameter int HIT_DIST       = 8
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic [10:0] BallX,
  input  logic [10:0] BallY,
  input  logic [10:0] GhostX,
  input  logic [10:0] GhostY,
  input  logic        power_pellet,
  output logic        blue,
  output logic        blue_flash,
  output logic        overg,
  output logic        over,
  output logic [7:0]  eaten_count
);

  if (BLUE_FRAMES < 1 || BLUE_FRAMES > 511 ||
      RESPAWN_FRAMES < 1 || RESPAWN_FRAMES > 511) begin : g_bad_param
    $error("ghost_mode_ctrl: BLUE_FRAMES and RESPAWN_FRAMES must be in 1..511");
  end

  localparam logic [8:0]  BLUE_T  = 9'(BLUE_FRAMES);
  localparam logic [8:0]  RESP_T  = 9'(RESPAWN_FRAMES);
  localparam logic [9:0]  FLASH_T = 10'(FLASH_FRAMES);
  localparam logic [11:0] HIT_D   = 12'(HIT_DIST);

  typedef enum logic [1:0] {
    CHASE  = 2'd0,
    FRIGHT = 2'd1,
    EATEN  = 2'd2,
    CAUGHT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  timer_q, timer_d;
  logic        overg_q, overg_d;
  logic        over_q, over_d;
  logic [7:0]  eaten_q, eaten_d;
  logic [10:0] dx, dy;
  logic        hit;

  // Compare first, then subtract the smaller operand, so no wrap can fake a hit.
  function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
    if (a >= b) return a - b;
    else        return b - a;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign dx  = abs_diff(BallX, GhostX);
  assign dy  = abs_diff(BallY, GhostY);
  assign hit = ({1'b0, dx} < HIT_D) && ({1'b0, dy} < HIT_D);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    overg_d = 1'b0;
    eaten_d = eaten_q;
    unique case (state_q)
      CHASE: begin
        if (hit) begin
          state_d = CAUGHT;
        end else if (power_pellet) begin
          state_d = FRIGHT;
          timer_d = BLUE_T;
        end
      end
      FRIGHT: begin
        if (hit) begin
          state_d = EATEN;
          timer_d = RESP_T;
          overg_d = 1'b1;
          eaten_d = sat_inc8(eaten_q);
        end else if (power_pellet) begin
          timer_d = BLUE_T;
        end else if (timer_q == 9'd1) begin
          state_d = CHASE;
          timer_d = 9'd0;
        end else begin
          timer_d = timer_q - 9'd1;
        end
      end
      EATEN: begin
        // Collisions and pellets are ignored while the ghost respawns.
        if (timer_q <= 9'd1) begin
          state_d = CHASE;
          timer_d = 9'd0;
        end else begin
          timer_d = timer_q - 9'd1;
        end
      end
      CAUGHT: begin
        state_d = CAUGHT;
      end
      default: begin
        state_d = CHASE;
        timer_d = 9'd0;
      end
    endcase
    over_d = (state_d == CAUGHT);
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= CHASE;
      timer_q <= 9'd0;
      overg_q <= 1'b0;
      over_q  <= 1'b0;
      eaten_q <= 8'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      overg_q <= overg_d;
      over_q  <= over_d;
      eaten_q <= eaten_d;
    end
  end

  assign blue        = (state_q == FRIGHT);
  assign blue_flash  = blue && ({1'b0, timer_q} <= FLASH_T);
  assign overg       = overg_q;
  assign over        = over_q;
  assign eaten_count = eaten_q;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Directed bench for ghost_mode_ctrl: catch, frightened timeout, eating,
// distance boundaries, pellet reload, async reset and count saturation.
module tb_ghost_mode_ctrl;

  logic        frame_clk = 1'b0;
  logic        Reset_n;
  logic [10:0] BallX, BallY, GhostX, GhostY;
  logic        power_pellet;
  logic        blue, blue_flash, overg, over;
  logic [7:0]  eaten_count;

  int n_checks = 0;
  int n_fail   = 0;

  ghost_mode_ctrl dut (
    .frame_clk   (frame_clk),
    .Reset_n     (Reset_n),
    .BallX       (BallX),
    .BallY       (BallY),
    .GhostX      (GhostX),
    .GhostY      (GhostY),
    .power_pellet(power_pellet),
    .blue        (blue),
    .blue_flash  (blue_flash),
    .overg       (overg),
    .over        (over),
    .eaten_count (eaten_count)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic b, input logic f,
                            input logic g, input logic o, input logic [7:0] c);
    chk({tag, ".blue"},  32'(blue),        32'(b));
    chk({tag, ".flash"}, 32'(blue_flash),  32'(f));
    chk({tag, ".overg"}, 32'(overg),       32'(g));
    chk({tag, ".over"},  32'(over),        32'(o));
    chk({tag, ".count"}, 32'(eaten_count), 32'(c));
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
  endtask

  task automatic ghost_far();
    GhostX = 11'd300;
    GhostY = 11'd300;
  endtask

  task automatic pellet_tick();
    power_pellet = 1'b1;
    tick();
    power_pellet = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0;
    BallX = 11'd100; BallY = 11'd100;
    ghost_far();
    power_pellet = 1'b0;

    // Reset and idle catch
    #3;
    check_outs("in_reset", 0, 0, 0, 0, 8'd0);
    tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_outs("idle", 0, 0, 0, 0, 8'd0);
    GhostX = 11'd105; GhostY = 11'd96;
    tick();
    check_outs("caught", 0, 0, 0, 1, 8'd0);
    power_pellet = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    power_pellet = 1'b0;
    check_outs("caught_hold", 0, 0, 0, 1, 8'd0);

    // Frightened timeout
    do_reset();
    ghost_far();
    pellet_tick();
    check_outs("fr0", 1, 0, 0, 0, 8'd0);
    for (int i = 1; i < 300; i++) begin
      tick();
      check_outs($sformatf("fr%0d", i), 1, (i >= 210), 0, 0, 8'd0);
    end
    tick();
    check_outs("fr300", 0, 0, 0, 0, 8'd0);

    // Ghost eaten, then held hit after respawn
    do_reset();
    ghost_far();
    pellet_tick();
    for (int i = 0; i < 3; i++) tick();
    GhostX = 11'd107; GhostY = 11'd100;
    tick();
    check_outs("eat", 0, 0, 1, 0, 8'd1);
    for (int i = 1; i <= 60; i++) begin
      tick();
      check_outs($sformatf("respawn%0d", i), 0, 0, 0, 0, 8'd1);
    end
    tick();
    check_outs("caught_after_respawn", 0, 0, 0, 1, 8'd1);

    // Boundary distance
    do_reset();
    ghost_far();
    pellet_tick();
    GhostX = 11'd108; GhostY = 11'd100;
    tick();
    check_outs("dx8", 1, 0, 0, 0, 8'd0);
    GhostX = 11'd100; GhostY = 11'd108;
    tick();
    check_outs("dy8", 1, 0, 0, 0, 8'd0);
    BallX = 11'd0; GhostX = 11'd2047; GhostY = 11'd100;
    tick();
    check_outs("nowrap", 1, 0, 0, 0, 8'd0);
    BallX = 11'd100; GhostX = 11'd93;
    tick();
    check_outs("eat_neg_dx", 0, 0, 1, 0, 8'd1);

    // Pellet reload
    do_reset();
    ghost_far();
    pellet_tick();
    for (int i = 1; i <= 249; i++) tick();
    check_outs("rl249", 1, 1, 0, 0, 8'd0);
    pellet_tick();
    check_outs("rl250", 1, 0, 0, 0, 8'd0);
    for (int i = 251; i <= 549; i++) tick();
    check_outs("rl549", 1, 1, 0, 0, 8'd0);
    tick();
    check_outs("rl550", 0, 0, 0, 0, 8'd0);

    // Saturation, then asynchronous reset mid-FRIGHT
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      ghost_far();
      pellet_tick();
      GhostX = 11'd107; GhostY = 11'd100;
      tick();
      if (k == 1 || k == 255 || k == 256 || k == 300)
        check_outs($sformatf("sat%0d", k), 0, 0, 1, 0, 8'((k > 255) ? 255 : k));
      ghost_far();
      for (int i = 0; i < 60; i++) tick();
    end
    pellet_tick();
    for (int i = 0; i < 150; i++) tick();
    check_outs("pre_async", 1, 0, 0, 0, 8'd255);
    #2;
    Reset_n = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 0, 0, 8'd0);
    Reset_n = 1'b1;
    tick();
    check_outs("post_rst", 0, 0, 0, 0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
